addsub_seq: RTL and testbench
=============================

ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; SHALL be a multiple of CHUNK and at least 2.
REQ-002 Parameter CHUNK, default 4: bits added per cycle. NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a new operation; sampled only while busy=0.
REQ-006 sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-007 a  input  WIDTH  operand A; sampled with start.
REQ-008 b  input  WIDTH  operand B; sampled with start.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when out, c_out and ovf become valid.
REQ-011 out  output  WIDTH  result.
REQ-012 c_out  output  1  carry out of the MSB (for subtraction, 1 = no borrow).
REQ-013 ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and DONE. busy=1 only in BUSY; done=1 only in DONE.
REQ-015 In IDLE or DONE, start=1 SHALL capture a, b XOR {WIDTH{sub}} and carry-in = sub, clear the chunk index, and enter BUSY.
REQ-016 In BUSY, each cycle SHALL add chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) of the captured operands with the registered carry. It SHALL store the chunk sum into an internal result register, register the chunk carry-out, and increment k.
REQ-017 After exactly NCHUNK BUSY cycles, the FSM SHALL enter DONE for one cycle, then IDLE unless start=1 in DONE.
REQ-018 Timing: with start high at rising edge n, busy SHALL be high for cycles n+1..n+NCHUNK and done SHALL be high in cycle n+NCHUNK+1. Back-to-back operations SHALL have a period of NCHUNK+1 cycles.
REQ-019 out, c_out and ovf SHALL update only on entry to DONE and hold their values until the next completion.
REQ-020 ovf SHALL equal (carry into MSB) XOR (carry out of MSB), computed within the final chunk.
REQ-021 start while busy=1 SHALL be ignored. Captured operands and sub SHALL be unaffected by input changes during BUSY.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, out=0, c_out=0, ovf=0, and clear all internal registers, including during BUSY.
REQ-023 The first rising edge with rst_n=1 and start=1 SHALL begin a normal operation.

Configuration
REQ-024 Macro ADDSUB_SEQ_SAT_EN.
- Defined: when ovf=1, out SHALL saturate to 0x7F..F if the captured a is non-negative, or 0x80..0 if it is negative. ovf and c_out SHALL be reported unchanged.
- Undefined: out SHALL be the wrapped WIDTH-bit sum.

Verification (WIDTH=16, CHUNK=4)
REQ-025 a=0x1234, b=0x0FFF, sub=0, start at edge n -> busy for cycles n+1..n+4; done in cycle n+5 only; out=0x2233, c_out=0, ovf=0.
REQ-026 a=0x7FFF, b=0x0001, sub=0 -> ovf=1, c_out=0; out=0x8000 without the macro, 0x7FFF with ADDSUB_SEQ_SAT_EN.
REQ-027 a=0x0000, b=0x0001, sub=1 -> out=0xFFFF, c_out=0, ovf=0. a=0x8000, b=0x0001, sub=1 -> out=0x7FFF, c_out=1, ovf=1; out=0x8000 with ADDSUB_SEQ_SAT_EN.
REQ-028 Issue 0x0001+0x0001, then pulse start with a=0xFFFF during cycle n+2 -> pulse ignored; done in n+5 with out=0x0002; no second done.
REQ-029 Drive rst_n=0 in cycle n+2 of an operation -> busy, done, out, c_out and ovf are 0 immediately. After release, 0x0003+0x0004 -> out=0x0007 after 5 cycles.
REQ-030 Hold start=1 continuously with a=0x0010, b=0x0001 -> done every 5th cycle, out=0x0011, busy low only in the DONE cycles.

Source files
------------

// File: rtl/addsub_seq.sv
// Sequential adder/subtractor: adds CHUNK bits per cycle over WIDTH/CHUNK cycles.
// Optional macro ADDSUB_SEQ_SAT_EN saturates the result on signed overflow.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             a_sign_q, a_sign_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic [KW-1:0]    k_q, k_d;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] chunk_top;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] result;
  logic             msb_cin;
  logic             ovf_now;
  logic             last_chunk;

  // Operands shift right each cycle so the active chunk is always at bit 0;
  // chunk sums enter the result from the top and settle in place after NCHUNK steps.
  always_comb begin
    chunk_sum = {1'b0, a_sh_q[CHUNK-1:0]} + {1'b0, b_sh_q[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, carry_q};
    chunk_top = '0;
    chunk_top[WIDTH-1 -: CHUNK] = chunk_sum[CHUNK-1:0];
    sum_next  = (sum_q >> CHUNK) | chunk_top;
    // Carry into a bit position is recoverable from its two inputs and its sum.
    msb_cin   = a_sh_q[CHUNK-1] ^ b_sh_q[CHUNK-1] ^ chunk_sum[CHUNK-1];
    ovf_now   = msb_cin ^ chunk_sum[CHUNK];
    last_chunk = (k_q == KW'(NCHUNK - 1));
`ifdef ADDSUB_SEQ_SAT_EN
    if (ovf_now) begin
      result = a_sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      result = sum_next;
    end
`else
    result = sum_next;
`endif
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_d    = sum_q;
    out_d    = out_q;
    carry_d  = carry_q;
    a_sign_d = a_sign_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    k_d      = k_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b ^ {WIDTH{sub}};
          carry_d  = sub;
          a_sign_d = a[WIDTH-1];
          sum_d    = '0;
          k_d      = '0;
          state_d  = S_BUSY;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_BUSY: begin
        a_sh_d  = a_sh_q >> CHUNK;
        b_sh_d  = b_sh_q >> CHUNK;
        sum_d   = sum_next;
        carry_d = chunk_sum[CHUNK];
        k_d     = k_q + KW'(1);
        if (last_chunk) begin
          out_d   = result;
          c_out_d = chunk_sum[CHUNK];
          ovf_d   = ovf_now;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_q    <= '0;
      out_q    <= '0;
      carry_q  <= 1'b0;
      a_sign_q <= 1'b0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_q    <= sum_d;
      out_q    <= out_d;
      carry_q  <= carry_d;
      a_sign_q <= a_sign_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      k_q      <= k_d;
    end
  end

  assign busy      = (state_q == S_BUSY);
  assign done      = (state_q == S_DONE);
  assign out       = out_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: directed cases plus randomized traffic
// checked every cycle against a phase-counting arithmetic model.
module tb_addsub_seq;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             c_out;
  logic             ovf;
  logic [1:0]       dbg_state;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  addsub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .out(out), .c_out(c_out), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {c_out, ovf, out} from plain integer arithmetic.
  function automatic logic [WIDTH+1:0] ref_calc(input logic [WIDTH-1:0] fa,
                                                 input logic [WIDTH-1:0] fb,
                                                 input logic fsub);
    longint sa, sb, st, umax;
    logic [WIDTH-1:0] r;
    logic c, o;
    sa = longint'($signed(fa));
    sb = longint'($signed(fb));
    st = fsub ? sa - sb : sa + sb;
    o  = (st > 32767) || (st < -32768);
    umax = 64'd1 << WIDTH;
    if (fsub) begin
      c = (longint'(fa) >= longint'(fb));
      r = WIDTH'(longint'(fa) - longint'(fb));
    end else begin
      c = ((longint'(fa) + longint'(fb)) >= umax);
      r = WIDTH'(longint'(fa) + longint'(fb));
    end
`ifdef ADDSUB_SEQ_SAT_EN
    if (o) r = fa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    return {c, o, r};
  endfunction

  // scoreboard: phase 0 idle, 1..NCHUNK working, NCHUNK+1 result cycle
  logic [WIDTH+1:0] exp_q[$];
  logic [WIDTH+1:0] hold = '0;
  int               ph   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph   = 0;
      hold = '0;
      exp_q.delete();
    end else if (ph == 0 || ph == NCHUNK + 1) begin
      if (start) begin
        exp_q.push_back(ref_calc(a, b, sub));
        ph = 1;
      end else begin
        ph = 0;
      end
    end else if (ph == NCHUNK) begin
      if (exp_q.size() > 0) hold = exp_q.pop_front();
      ph = NCHUNK + 1;
    end else begin
      ph = ph + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",  WIDTH'(busy),  WIDTH'(ph >= 1 && ph <= NCHUNK));
      chk("done",  WIDTH'(done),  WIDTH'(ph == NCHUNK + 1));
      chk("out",   out,           hold[WIDTH-1:0]);
      chk("c_out", WIDTH'(c_out), WIDTH'(hold[WIDTH+1]));
      chk("ovf",   WIDTH'(ovf),   WIDTH'(hold[WIDTH]));
    end
  end

  // driver tasks
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic ts, input logic [WIDTH-1:0] e_out,
                        input logic e_c, input logic e_o, input string tag);
    int lat;
    bit got;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; sub = ts;
    lat = 0; got = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got = 1; lat = i;
        chk({tag, "_out"},   out,           e_out);
        chk({tag, "_c_out"}, WIDTH'(c_out), WIDTH'(e_c));
        chk({tag, "_ovf"},   WIDTH'(ovf),   WIDTH'(e_o));
      end else if (i <= NCHUNK) begin
        chk({tag, "_busy"},  WIDTH'(busy),  WIDTH'(1));
      end
    end
    chk({tag, "_latency"}, WIDTH'(lat), WIDTH'(5));
  endtask

  // Caller is positioned at a falling edge; reset lands mid-cycle.
  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rst_busy"},  WIDTH'(busy),  WIDTH'(0));
    chk({tag, "_rst_done"},  WIDTH'(done),  WIDTH'(0));
    chk({tag, "_rst_out"},   out,           WIDTH'(0));
    chk({tag, "_rst_c_out"}, WIDTH'(c_out), WIDTH'(0));
    chk({tag, "_rst_ovf"},   WIDTH'(ovf),   WIDTH'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(WIDTH-1){1'b0}}};
      3: return {1'b0, {(WIDTH-1){1'b1}}};
      default: return WIDTH'($urandom);
    endcase
  endfunction

  logic [WIDTH-1:0] sat_pos, sat_neg;
  int n_done, first_done;

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    @(negedge clk);
    chk_en = 1;
    chk("reset_busy", WIDTH'(busy), WIDTH'(0));
    chk("reset_out",  out,          WIDTH'(0));
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ADDSUB_SEQ_SAT_EN
    sat_pos = 16'h7FFF; sat_neg = 16'h8000;
`else
    sat_pos = 16'h8000; sat_neg = 16'h7FFF;
`endif
    run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "add_basic");
    run_op(16'h7FFF, 16'h0001, 1'b0, sat_pos,  1'b0, 1'b1, "add_ovf");
    run_op(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub_borrow");
    run_op(16'h8000, 16'h0001, 1'b1, sat_neg,  1'b1, 1'b1, "sub_ovf");

    // start pulse while busy must be ignored
    @(negedge clk);
    start = 1'b1; a = 16'h0001; b = 16'h0001; sub = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; a = 16'hFFFF;
    @(negedge clk); start = 1'b0;
    n_done = 0; first_done = 0;
    for (int c = 4; c <= 14; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_done == 0) begin
          first_done = c;
          chk("ignore_out", out, 16'h0002);
        end
      end
    end
    chk("ignore_ndone", WIDTH'(n_done), WIDTH'(1));
    chk("ignore_lat",   WIDTH'(first_done), WIDTH'(5));

    // reset in the middle of an operation, then a clean operation
    @(negedge clk);
    start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    mid_reset("mid");
    run_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, "after_rst");

    // start held high: back-to-back operations every NCHUNK+1 cycles
    @(negedge clk);
    start = 1'b1; a = 16'h0010; b = 16'h0001; sub = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        chk("b2b_out",  out, 16'h0011);
        chk("b2b_slot", WIDTH'(c % 5), WIDTH'(0));
      end
    end
    chk("b2b_ndone", WIDTH'(n_done), WIDTH'(4));
    start = 1'b0;
    repeat (6) @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a = pick(); b = pick(); sub = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) mid_reset("rand");
    end

    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("drain_queue", WIDTH'(exp_q.size()), WIDTH'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
